// File: rtl/endec_stream_ctrl.sv
// Stream front-end for a handshake-driven nibble EnDecoder: queues requests in a
// small FIFO, issues them one at a time with a bounded wait, and holds each result for downstream.
module endec_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [3:0] in_code_i,
  input  logic [3:0] in_key_i,
  input  logic       in_mode_i,
  output logic [3:0] core_code_o,
  output logic [3:0] core_key_o,
  output logic       core_mode_o,
  output logic       core_start_o,
  input  logic [3:0] core_code_i,
  input  logic       core_done_i,
  output logic       out_valid_o,
  output logic [3:0] out_code_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic       mode;
    logic [3:0] key;
    logic [3:0] code;
  } entry_t;

  state_t        state_q, state_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        head, in_entry;
  entry_t        core_q, core_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [3:0]    out_code_q, out_code_d;
  logic          err_q, err_d;
  logic          push, pop;

  assign in_entry   = {in_mode_i, in_key_i, in_code_i};
  assign head       = mem_q[rd_ptr_q];
  assign in_ready_o = (count_q < DEPTH_C);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    core_d       = core_q;
    out_code_d   = out_code_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    core_start_o = 1'b0;
    out_valid_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          core_d  = head;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Suppressed combinationally so a reset landing here never leaks a pulse.
        core_start_o = !rst_i;
        tmo_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          out_code_d = core_code_i;
          state_d    = S_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_HOLD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      core_q     <= '0;
      out_code_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      core_q     <= core_d;
      out_code_q <= out_code_d;
      err_q      <= err_d;
    end
  end

  assign core_code_o = core_q.code;
  assign core_key_o  = core_q.key;
  assign core_mode_o = core_q.mode;
  assign out_code_o  = out_code_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_endec_stream_ctrl.sv
// Directed bench for endec_stream_ctrl; the EnDecoder side is driven by hand
// so done timing is exact. Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_endec_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [3:0] in_code_i = '0;
  logic [3:0] in_key_i = '0;
  logic       in_mode_i = 1'b0;
  logic [3:0] core_code_o;
  logic [3:0] core_key_o;
  logic       core_mode_o;
  logic       core_start_o;
  logic [3:0] core_code_i = '0;
  logic       core_done_i = 1'b0;
  logic       out_valid_o;
  logic [3:0] out_code_o;
  logic       out_ready_i = 1'b0;
  logic       busy_o;
  logic       err_o;

  int checks   = 0;
  int failures = 0;

  endec_stream_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_code_i   (in_code_i),
    .in_key_i    (in_key_i),
    .in_mode_i   (in_mode_i),
    .core_code_o (core_code_o),
    .core_key_o  (core_key_o),
    .core_mode_o (core_mode_o),
    .core_start_o(core_start_o),
    .core_code_i (core_code_i),
    .core_done_i (core_done_i),
    .out_valid_o (out_valid_o),
    .out_code_o  (out_code_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    core_done_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic drive(input logic [3:0] code, input logic [3:0] key, input logic mode);
    in_valid_i = 1'b1;
    in_code_i  = code;
    in_key_i   = key;
    in_mode_i  = mode;
  endtask

  // {core_mode, core_key, core_code} as one 9-bit word
  function automatic logic [8:0] core_word();
    return {core_mode_o, core_key_o, core_code_o};
  endfunction

  // {in_ready, busy, err, out_valid, start, core_mode} and {core_key, core_code, out_code}
  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"}, {in_ready_o, busy_o, err_o, out_valid_o, core_start_o, core_mode_o}, 6'b100000);
    check({tag, "_data"}, {core_key_o, core_code_o, out_code_o}, 12'h000);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!core_start_o && n < 10) begin
      tick();
      n++;
    end
    check(tag, core_start_o, 1'b1);
  endtask

  // Called in the ISSUE cycle: answer in the first WAIT cycle, then drain HOLD.
  task automatic finish_one(input string tag, input logic [3:0] res);
    tick();
    core_done_i = 1'b1;
    core_code_i = res;
    tick();
    core_done_i = 1'b0;
    check({tag, "_hold"}, {out_valid_o, out_code_o}, {1'b1, res});
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_drop"}, out_valid_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    check_reset_vals("reset");

    // Single transaction, done three cycles after start
    drive(4'hA, 4'h3, 1'b0);
    tick();
    in_valid_i = 1'b0;
    check("t1_no_start_k", {core_start_o, busy_o}, 2'b01);
    tick();
    check("t1_start_k1", core_start_o, 1'b1);
    check("t1_core_word", core_word(), 9'h03A);
    tick();
    check("t1_start_one_cycle", core_start_o, 1'b0);
    tick();
    tick();
    core_done_i = 1'b1;
    core_code_i = 4'h5;
    check("t1_core_stable", core_word(), 9'h03A);
    tick();
    core_done_i = 1'b0;
    check("t1_result", {out_valid_o, out_code_o}, 5'h15);
    core_done_i = 1'b1;
    core_code_i = 4'hC;
    tick();
    core_done_i = 1'b0;
    check("t1_hold_ignores_done", {out_valid_o, out_code_o}, 5'h15);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("t1_cleared", {out_valid_o, busy_o, err_o}, 3'b000);

    // Push and pop on the same edge keep count and order
    drive(4'h1, 4'h1, 1'b0);
    tick();
    drive(4'h2, 4'h2, 1'b1);
    tick();
    in_valid_i = 1'b0;
    check("t2_start0", core_start_o, 1'b1);
    check("t2_word0", core_word(), 9'h011);
    finish_one("t2_r0", 4'hE);
    wait_start("t2_start1");
    check("t2_word1", core_word(), 9'h122);
    finish_one("t2_r1", 4'h6);
    check("t2_empty", busy_o, 1'b0);

    // Timeout with no done, then a normal transaction
    drive(4'h7, 4'h1, 1'b0);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("t3_start", core_start_o, 1'b1);
    tick();
    for (int j = 1; j < TMO; j++) tick();
    check("t3_no_err_early", err_o, 1'b0);
    tick();
    check("t3_err_set", {err_o, busy_o, out_valid_o}, 3'b100);
    drive(4'h3, 4'h4, 1'b1);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("t3_next_start", core_start_o, 1'b1);
    check("t3_next_word", core_word(), 9'h143);
    finish_one("t3_next", 4'h9);
    check("t3_err_sticky", err_o, 1'b1);

    // Done on the very cycle the timeout would expire
    do_reset();
    check("t4_err_cleared", err_o, 1'b0);
    drive(4'h5, 4'h5, 1'b0);
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    for (int j = 1; j < TMO; j++) tick();
    core_done_i = 1'b1;
    core_code_i = 4'hB;
    tick();
    core_done_i = 1'b0;
    check("t4_done_wins", {err_o, out_valid_o, out_code_o}, 6'h1B);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;

    // Fill the FIFO while the FSM stalls in HOLD
    do_reset();
    drive(4'h8, 4'h0, 1'b0);
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    core_done_i = 1'b1;
    core_code_i = 4'h0;
    tick();
    core_done_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(4'(9 + i), 4'(i + 1), 1'b0);
      check($sformatf("t5_ready_%0d", i), in_ready_o, 1'b1);
      tick();
    end
    drive(4'hD, 4'h5, 1'b0);
    check("t5_full", in_ready_o, 1'b0);
    tick();
    check("t5_fifth_held", {in_ready_o, out_valid_o}, 2'b01);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("t5_full_idle", {in_ready_o, core_start_o}, 2'b00);
    tick();
    check("t5_pop_b", {core_start_o, in_ready_o, core_code_o}, 6'h39);
    tick();
    in_valid_i = 1'b0;
    check("t5_refull", in_ready_o, 1'b0);
    core_done_i = 1'b1;
    core_code_i = 4'h6;
    tick();
    core_done_i = 1'b0;
    check("t5_res_b", {out_valid_o, out_code_o}, 5'h16);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] c;
      c = 4'(4'hA + i);
      wait_start($sformatf("t5_start_%0d", i));
      check($sformatf("t5_order_%0d", i), core_code_o, c);
      finish_one($sformatf("t5_res_%0d", i), c ^ 4'hF);
    end
    check("t5_drained", busy_o, 1'b0);

    // Reset while in WAIT with two entries queued
    drive(4'h1, 4'h1, 1'b0);
    tick();
    drive(4'h2, 4'h2, 1'b0);
    tick();
    drive(4'h3, 4'h3, 1'b0);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("t6_busy_wait", busy_o, 1'b1);
    rst_i = 1'b1;
    tick();
    check_reset_vals("t6_reset");
    tick();
    rst_i = 1'b0;
    core_done_i = 1'b1;
    core_code_i = 4'h7;
    tick();
    core_done_i = 1'b0;
    check("t6_late_done", {out_valid_o, out_code_o, busy_o, core_start_o}, 7'h00);
    tick();
    check("t6_discarded", {busy_o, core_start_o}, 2'b00);

    // Reset landing in ISSUE suppresses the start pulse
    drive(4'h4, 4'h4, 1'b0);
    tick();
    in_valid_i = 1'b0;
    tick();
    check("t7_issue", core_start_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("t7_start_gated", core_start_o, 1'b0);
    tick();
    rst_i = 1'b0;
    check("t7_after_reset", {busy_o, core_start_o, in_ready_o}, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
